// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: MEM-stage sequencer for a variable-latency data memory plus load-use hazard bubbling; optional access timeout via MEM_STALL_CTRL_TIMEOUT_EN
module mem_stall_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic [31:0]      exmem_aluresult,
  input  logic [31:0]      exmem_wdata,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      ld_data,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic mem_op, mem_stall, hazard, timeout;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  assign mem_op = exmem_memread || exmem_memwrite;
  assign mem_stall = (state == IDLE && mem_op) || state == ACCESS;
  assign hazard = idex_memread && idex_rd != 5'd0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
  // A memory stall freezes everything upstream and dominates the load-use hazard
  assign pc_we = !mem_stall && !hazard;
  assign ifid_we = !mem_stall && !hazard;
  assign idex_we = !mem_stall;
  assign exmem_we = !mem_stall;
  assign idex_bubble = !mem_stall && hazard;
  assign memwb_bubble = mem_stall;
`ifdef MEM_STALL_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1) < 8 ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign timeout = tcnt == TW'(TIMEOUT_CYCLES - 1);
  // Access timer is zero outside ACCESS so it starts cleared on every entry; timeout error is sticky
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt <= '0;
      mem_err <= 1'b0;
    end else begin
      tcnt <= state == ACCESS ? tcnt + 1'b1 : '0;
      if (state == ACCESS && !mem_ready && timeout) mem_err <= 1'b1;
    end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif
  // Access FSM: latch the request on leaving IDLE, hold it through ACCESS, release for one DONE cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      ld_data <= '0;
    end else begin
      case (state)
        IDLE: if (mem_op) begin
          mem_req <= 1'b1;
          mem_we <= exmem_memwrite;
          mem_addr <= {exmem_aluresult[31:2], 2'b00};
          mem_wdata <= exmem_wdata;
          state <= ACCESS;
        end
        ACCESS: if (mem_ready || timeout) begin
          if (!mem_we) ld_data <= mem_ready ? mem_rdata : '0;
          mem_req <= 1'b0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  // Saturating count of cycles in which EX/MEM is frozen
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (!exmem_we && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: directed vector table plus multi-cycle sequences for mem_stall_ctrl
module tb_mem_stall_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic exmem_memread, exmem_memwrite;
  logic [31:0] exmem_aluresult, exmem_wdata;
  logic idex_memread;
  logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
  logic mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic mem_ready;
  logic [31:0] mem_rdata, ld_data;
  logic pc_we, ifid_we, idex_we, exmem_we, idex_bubble, memwb_bubble, mem_err;
  logic [15:0] stall_cnt;
  logic [5:0] ctl;
  int checks = 0;
  int errors = 0;

  mem_stall_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .exmem_aluresult(exmem_aluresult), .exmem_wdata(exmem_wdata),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ld_data(ld_data),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  assign ctl = {pc_we, ifid_we, idex_we, exmem_we, idex_bubble, memwb_bubble};

  typedef struct {
    logic mrd, mwr, imr;
    logic [4:0] rd, rs1, rs2;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    exmem_memread = 1'b0;
    exmem_memwrite = 1'b0;
    idex_memread = 1'b0;
    idex_rd = 5'd0;
    ifid_rs1 = 5'd0;
    ifid_rs2 = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, n;
    logic prev;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 6'b111100};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 6'b001110};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 6'b001110};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 6'b111100};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 6'b111100};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 5'd5, 5'd6, 5'd7, 6'b111100};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 6'b000001};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 6'b000001};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 6'b000001};
    rst_n = 1'b0;
    idle_inputs();
    exmem_aluresult = '0;
    exmem_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      exmem_memread = vecs[i].mrd;
      exmem_memwrite = vecs[i].mwr;
      idex_memread = vecs[i].imr;
      idex_rd = vecs[i].rd;
      ifid_rs1 = vecs[i].rs1;
      ifid_rs2 = vecs[i].rs2;
      #1 chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].exp));
      #1 idle_inputs();
    end
    @(negedge clk);
    chk("vec_stall_cnt", 32'(stall_cnt), 0);

    exmem_memread = 1'b1;
    exmem_aluresult = 32'h0000_1006;
    #1 chk("ld_idle_stall", 32'(exmem_we), 0);
    @(negedge clk);
    chk("ld_req", 32'(mem_req), 1);
    chk("ld_addr", mem_addr, 32'h0000_1004);
    chk("ld_we", 32'(mem_we), 0);
    chk("ld_access_ctl", 32'(ctl), 32'b000001);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("ld_done_ctl", 32'(ctl), 32'b111100);
    chk("ld_done_req", 32'(mem_req), 0);
    chk("ld_data", ld_data, 32'hDEAD_BEEF);
    chk("ld_stall_cnt", 32'(stall_cnt), 2);
    exmem_memread = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("ld_idle_stall_cnt", 32'(stall_cnt), 2);

    exmem_memwrite = 1'b1;
    exmem_aluresult = 32'h0000_2003;
    exmem_wdata = 32'h1234_5678;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      exmem_aluresult = 32'hFFFF_FFFF;
      exmem_wdata = 32'hFFFF_FFFF;
      chk($sformatf("st_req%0d", i), 32'(mem_req), 1);
      chk($sformatf("st_we%0d", i), 32'(mem_we), 1);
      chk($sformatf("st_addr%0d", i), mem_addr, 32'h0000_2000);
      chk($sformatf("st_wdata%0d", i), mem_wdata, 32'h1234_5678);
      if (i == 4) mem_ready = 1'b1;
    end
    @(negedge clk);
    chk("st_done_req", 32'(mem_req), 0);
    chk("st_done_exmem_we", 32'(exmem_we), 1);
    chk("st_ld_data_kept", ld_data, 32'hDEAD_BEEF);
    chk("st_stall_cnt", 32'(stall_cnt), 7);
    exmem_memwrite = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);

    exmem_memread = 1'b1;
    exmem_aluresult = 32'h0000_0040;
    idex_memread = 1'b1;
    idex_rd = 5'd3;
    ifid_rs1 = 5'd3;
    #1 chk("hz_idle_ctl", 32'(ctl), 32'b000001);
    @(negedge clk);
    chk("hz_access_ctl", 32'(ctl), 32'b000001);
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("hz_done_ctl", 32'(ctl), 32'b001110);
    chk("hz_ld_data", ld_data, 32'h0BAD_F00D);
    chk("hz_stall_cnt", 32'(stall_cnt), 9);
    idle_inputs();
    mem_ready = 1'b0;
    @(negedge clk);

    exmem_memread = 1'b1;
    exmem_aluresult = 32'h0000_0100;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_req && !prev) rises++;
      prev = mem_req;
      if (i == 4) exmem_memread = 1'b0;
    end
    chk("b2b_req_pulses", 32'(rises), 2);
    chk("b2b_stall_cnt", 32'(stall_cnt), 13);
    chk("b2b_ld_data", ld_data, 32'hCAFE_F00D);
    mem_ready = 1'b0;
    @(negedge clk);

    exmem_memread = 1'b1;
    @(negedge clk);
    chk("rst_mid_req_before", 32'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_req", 32'(mem_req), 0);
    chk("rst_mid_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_mid_ld_data", ld_data, 0);
    exmem_memread = 1'b0;
    #1 chk("rst_mid_idle", 32'(memwb_bubble), 0);
    @(negedge clk);
    rst_n = 1'b1;

    exmem_memread = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h55AA_55AA;
    @(negedge clk);
    @(negedge clk);
    chk("pre_to_ld_data", ld_data, 32'h55AA_55AA);
    mem_ready = 1'b0;
    @(negedge clk);
    n = 0;
`ifdef MEM_STALL_CTRL_TIMEOUT_EN
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_req) break;
      n++;
    end
    chk("to_req_cycles", 32'(n), 8);
    chk("to_mem_err", 32'(mem_err), 1);
    chk("to_ld_data", ld_data, 0);
    chk("to_resume", 32'(exmem_we), 1);
    chk("to_stall_cnt", 32'(stall_cnt), 11);
    exmem_memread = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_err_sticky", 32'(mem_err), 1);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) n++;
    end
    chk("wait_req_cycles", 32'(n), 20);
    chk("wait_stalled", 32'(exmem_we), 0);
    mem_ready = 1'b1;
    mem_rdata = 32'h7777_0000;
    @(negedge clk);
    exmem_memread = 1'b0;
    mem_ready = 1'b0;
    chk("wait_done_req", 32'(mem_req), 0);
    chk("wait_ld_data", ld_data, 32'h7777_0000);
    chk("wait_mem_err", 32'(mem_err), 0);
`endif
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
